// File: rtl/conv_idx_gen.sv
// Convolution index sequencer: walks every (x, y) pair of two runtime-sized
// operands and emits x/y plus z = x + y + base over a valid/ready handshake.
module conv_idx_gen #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] size_x,
    input  logic [IDX_W-1:0] size_y,
    input  logic [IDX_W:0]   z_base,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] x_idx,
    output logic [IDX_W-1:0] y_idx,
    output logic [IDX_W:0]   z_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam int ZW = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] x_q, x_d, y_q, y_d;
    logic [IDX_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [ZW-1:0]    z_q, z_d, zb_q, zb_d;
    logic             valid_q, valid_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [IDX_W-1:0] sx_m1, sy_m1, x_inc, y_inc;
    logic             idx_upd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            zb_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            zb_q    <= zb_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        sx_m1   = sx_q - IDX_W'(1);
        sy_m1   = sy_q - IDX_W'(1);
        x_inc   = x_q + IDX_W'(1);
        y_inc   = y_q + IDX_W'(1);

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        zb_d    = zb_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_upd = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    sx_d   = size_x;
                    sy_d   = size_y;
                    zb_d   = z_base;
                    busy_d = 1'b1;
                    if (size_x == '0 || size_y == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        x_d     = '0;
                        y_d     = '0;
                        idx_upd = 1'b1;
                        valid_d = 1'b1;
                        last_d  = (size_x == IDX_W'(1)) && (size_y == IDX_W'(1));
                    end
                end
            end
            S_RUN: begin
                // y is the inner loop; last is predicted from the next indices
                if (valid_q && out_ready) begin
                    idx_upd = 1'b1;
                    if (y_q != sy_m1) begin
                        y_d    = y_inc;
                        last_d = (x_q == sx_m1) && (y_inc == sy_m1);
                    end else begin
                        y_d = '0;
                        if (x_q != sx_m1) begin
                            x_d    = x_inc;
                            last_d = (x_inc == sx_m1) && (sy_m1 == '0);
                        end else begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (idx_upd)
            z_d = ZW'(x_d) + ZW'(y_d) + zb_d;

        // abort overrides everything above, including a final handshake
        if (abort) begin
            state_d = S_IDLE;
            x_d     = x_q;
            y_d     = y_q;
            z_d     = z_q;
            sx_d    = sx_q;
            sy_d    = sy_q;
            zb_d    = zb_q;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign x_idx     = x_q;
    assign y_idx     = y_q;
    assign z_idx     = z_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_idx_gen.sv
// Directed bench for conv_idx_gen: expected tuples are queued when a job is
// launched and popped on every observed handshake.
module tb_conv_idx_gen;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rstn, start, abort, out_ready;
    logic [IDX_W-1:0] size_x, size_y;
    logic [IDX_W:0]   z_base;
    logic             out_valid, out_last, busy, done;
    logic [IDX_W-1:0] x_idx, y_idx;
    logic [IDX_W:0]   z_idx;

    conv_idx_gen #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .size_x(size_x), .size_y(size_y), .z_base(z_base), .out_ready(out_ready),
        .out_valid(out_valid), .x_idx(x_idx), .y_idx(y_idx), .z_idx(z_idx),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] x;
        logic [IDX_W-1:0] y;
        logic [IDX_W:0]   z;
        logic             last;
    } tup_t;

    tup_t exp_q[$];
    tup_t prev_t;
    int   n_cmp = 0, n_err = 0;
    int   tick_no = 0, n_hs = 0, n_done = 0;
    int   done_tick = 0, last_hs_tick = 0, acc = 0, done_snap = 0;
    bit   done_seen = 0, prev_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_job(input int sx, input int sy, input int zb, input int limit);
        tup_t t;
        int   n = 0;
        for (int x = 0; x < sx; x++)
            for (int y = 0; y < sy; y++) begin
                if (n < limit) begin
                    t.x    = 6'(x);
                    t.y    = 6'(y);
                    t.z    = 7'((x + y + zb) % 128);
                    t.last = (x == sx - 1) && (y == sy - 1);
                    exp_q.push_back(t);
                end
                n++;
            end
    endtask

    // Monitor the current cycle (at its negedge), then advance one cycle.
    task automatic tick();
        tup_t cur, e;
        if (rstn) begin
            cur = {x_idx, y_idx, z_idx, out_last};
            if (prev_stall && out_valid)
                chk("stall_hold", 32'(cur), 32'(prev_t));
            if (out_valid && out_ready) begin
                n_hs++;
                last_hs_tick = tick_no;
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("tuple", 32'(cur), 32'(e));
            end
            prev_stall = out_valid && !out_ready;
            prev_t     = cur;
            if (done) begin
                n_done++;
                done_seen = 1;
                done_tick = tick_no;
                chk("busy_with_done", 32'(busy), 32'(1));
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tick_no++;
    endtask

    task automatic run_job(input int sx, input int sy, input int zb, input int rmode, input int budget);
        int p = 0;
        push_job(sx, sy, zb, sx * sy);
        n_hs      = 0;
        done_seen = 0;
        size_x    = 6'(sx);
        size_y    = 6'(sy);
        z_base    = 7'(zb);
        out_ready = 1'b1;
        start     = 1'b1;
        acc       = tick_no;
        tick();
        start = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) begin
            out_ready = (rmode == 0) ? 1'b1 : ((p % 3) == 0);
            p++;
            tick();
        end
        chk("done_seen", 32'(done_seen), 32'(1));
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("hs_count", 32'(n_hs), 32'(sx * sy));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        size_x = '0; size_y = '0; z_base = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_x", 32'(x_idx), 32'(0));
        chk("rst_y", 32'(y_idx), 32'(0));
        chk("rst_z", 32'(z_idx), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 3x2 job, ready tied high
        run_job(3, 2, 0, 0, 20);
        chk("j1_latency", 32'(done_tick - acc), 32'(7));
        chk("j1_idle_busy", 32'(busy), 32'(0));
        chk("j1_idle_valid", 32'(out_valid), 32'(0));

        // same job with back-pressure
        run_job(3, 2, 0, 1, 60);
        chk("j2_done_after_hs", 32'(done_tick - last_hs_tick), 32'(1));

        // full-size job with z wrap
        run_job(63, 63, 127, 0, 5000);
        chk("j3_latency", 32'(done_tick - acc), 32'(3970));

        // zero-size start, start ignored in DONE, accepted back in IDLE
        size_x = 6'd0; size_y = 6'd5; z_base = 7'd0; start = 1'b1; out_ready = 1'b1;
        tick();
        chk("zs_done", 32'(done), 32'(1));
        chk("zs_busy", 32'(busy), 32'(1));
        chk("zs_valid", 32'(out_valid), 32'(0));
        size_x = 6'd1; size_y = 6'd1; z_base = 7'd9;
        tick();
        chk("zs_ignored_valid", 32'(out_valid), 32'(0));
        chk("zs_ignored_busy", 32'(busy), 32'(0));
        chk("zs_done_clear", 32'(done), 32'(0));
        push_job(1, 1, 9, 1);
        done_seen = 0; n_hs = 0;
        tick();
        start = 1'b0;
        chk("zs_restart_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 10 && !done_seen; i++) tick();
        chk("zs_restart_done", 32'(done_seen), 32'(1));
        chk("zs_restart_hs", 32'(n_hs), 32'(1));

        // abort with start on the 3rd handshake of a 4x4 job
        push_job(4, 4, 0, 3);
        size_x = 6'd4; size_y = 6'd4; z_base = 7'd0; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        done_snap = n_done;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_valid", 32'(out_valid), 32'(0));
        chk("ab_last", 32'(out_last), 32'(0));
        chk("ab_busy", 32'(busy), 32'(0));
        chk("ab_x_hold", 32'(x_idx), 32'(0));
        chk("ab_y_hold", 32'(y_idx), 32'(2));
        for (int i = 0; i < 4; i++) tick();
        chk("ab_no_done", 32'(n_done), 32'(done_snap));
        chk("ab_queue", 32'(exp_q.size()), 32'(0));
        run_job(4, 4, 5, 0, 40);

        // async reset mid-run
        push_job(3, 3, 0, 9);
        size_x = 6'd3; size_y = 6'd3; z_base = 7'd0; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'(0));
        chk("ar_xyz", 32'({x_idx, y_idx, z_idx}), 32'(0));
        chk("ar_last", 32'(out_last), 32'(0));
        chk("ar_busy", 32'(busy), 32'(0));
        chk("ar_done", 32'(done), 32'(0));
        exp_q.delete();
        prev_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        done_snap = n_done;
        run_job(2, 2, 3, 0, 20);
        chk("ar_latency", 32'(done_tick - acc), 32'(5));
        chk("ar_one_done", 32'(n_done - done_snap), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
